// File: rtl/alu_ctrl_pkg.sv
// Shared types and default constants for the shared-ALU arbiter.
package alu_ctrl_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OP_W  = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_NOR  = 3'd5,
        OP_SLT  = 3'd6,
        OP_RSVD = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: (op, a, b) -> (result, zero, err).
module alu_core
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OP_W  = ALU_OP_W
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             err_o
);

    logic [WIDTH-1:0] result_s;
    logic             err_s;

    // Opcode decode; carry and overflow are simply discarded by the width.
    always_comb begin
        result_s = '0;
        err_s    = 1'b0;
        case (alu_op_e'(op_i))
            OP_ADD:  result_s = a_i + b_i;
            OP_SUB:  result_s = a_i - b_i;
            OP_AND:  result_s = a_i & b_i;
            OP_OR:   result_s = a_i | b_i;
            OP_XOR:  result_s = a_i ^ b_i;
            OP_NOR:  result_s = ~(a_i | b_i);
            OP_SLT:  result_s = ($signed(a_i) < $signed(b_i)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
            OP_RSVD: begin
                result_s = '0;
                err_s    = 1'b1;
            end
            default: begin
                result_s = '0;
                err_s    = 1'b0;
            end
        endcase
    end

    assign result_o = result_s;
    assign zero_o   = (result_s == '0);
    assign err_o    = err_s;

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end to one shared ALU, one op in flight.
module alu_share_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OP_W  = ALU_OP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err
);

    arb_state_e       state_q;
    logic             last_grant_q;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_zero_q;
    logic             rsp_err_q;

    logic             grant0_s;
    logic             grant1_s;
    logic [WIDTH-1:0] alu_result_s;
    logic             alu_zero_s;
    logic             alu_err_s;

    // Round-robin grant, only offered while idle; a tie goes to whoever was not served last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_q == ST_IDLE) && !reset) begin
            if (req0_valid && req1_valid) begin
                grant0_s = last_grant_q;
                grant1_s = !last_grant_q;
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    alu_core #(
        .WIDTH (WIDTH),
        .OP_W  (OP_W)
    ) u_alu_core (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result_s),
        .zero_o   (alu_zero_s),
        .err_o    (alu_err_s)
    );

    // Control FSM with operand capture and registered response; reset drops any op in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant0_s || grant1_s) begin
                        op_q         <= grant1_s ? req1_op : req0_op;
                        a_q          <= grant1_s ? req1_a  : req0_a;
                        b_q          <= grant1_s ? req1_b  : req0_b;
                        id_q         <= grant1_s;
                        last_grant_q <= grant1_s;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data_q  <= alu_result_s;
                    rsp_zero_q  <= alu_zero_s;
                    rsp_err_q   <= alu_err_s;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized bench for alu_share_arbiter with a behavioural reference model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [31:0] rsp_data;

    int n_assert = 0;
    int n_fail   = 0;
    bit model_last;   // requester served most recently (1 after reset)

    alu_share_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference ALU straight from the opcode table.
    function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] d, output logic e);
        e = 1'b0;
        case (op)
            3'd0:    d = a + b;
            3'd1:    d = a - b;
            3'd2:    d = a & b;
            3'd3:    d = a | b;
            3'd4:    d = a ^ b;
            3'd5:    d = ~(a | b);
            3'd6:    d = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: begin d = 32'd0; e = 1'b1; end
        endcase
    endfunction

    // Scramble requester inputs after an accept; valids random too.
    task automatic scramble();
        req0_valid = 1'($urandom_range(0, 1));
        req1_valid = 1'($urandom_range(0, 1));
        req0_op = 3'($urandom); req1_op = 3'($urandom);
        req0_a = $urandom; req0_b = $urandom;
        req1_a = $urandom; req1_b = $urandom;
    endtask

    // One full transaction; at least one of v0/v1 must be set.
    task automatic txn(input bit v0, input bit v1,
                       input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                       input int stall);
        bit          win;
        logic [31:0] ed;
        logic        ee;
        @(negedge clk);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp_ready  = 1'b0;
        win = (v0 && v1) ? !model_last : v1;
        #1;
        chk("accept_ready0", 32'(req0_ready), 32'(!win));
        chk("accept_ready1", 32'(req1_ready), 32'(win));
        if (win) ref_alu(op1, a1, b1, ed, ee);
        else     ref_alu(op0, a0, b0, ed, ee);
        model_last = win;
        @(posedge clk);
        #1;
        scramble();
        @(negedge clk);
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("exec_ready0", 32'(req0_ready), 32'd0);
        chk("exec_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(win));
        chk("rsp_data", rsp_data, ed);
        chk("rsp_zero", 32'(rsp_zero), 32'(ed == 32'd0));
        chk("rsp_err", 32'(rsp_err), 32'(ee));
        for (int i = 0; i < stall; i++) begin
            scramble();
            #1;
            chk("stall_ready0", 32'(req0_ready), 32'd0);
            chk("stall_ready1", 32'(req1_ready), 32'd0);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", rsp_data, ed);
            chk("stall_id", 32'(rsp_id), 32'(win));
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 3'd0; req1_op = 3'd0;
        req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
        rsp_ready = 1'b0;
        model_last = 1'b1;
        #12;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_ready0", 32'(req0_ready), 32'd0);
        chk("reset_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Both valid after reset: req0 first, then req1.
        txn(1'b1, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'd0, 3'd2, 32'hFFFF_FFFF, 32'd0, 0);
        txn(1'b1, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'd0, 3'd2, 32'hFFFF_FFFF, 32'd0, 0);
        // Req0 only, NOR of zeros.
        txn(1'b1, 1'b0, 3'd5, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 0);
        // Backpressure for 4 cycles on ADD 7+8.
        txn(1'b1, 1'b0, 3'd0, 32'd7, 32'd8, 3'd0, 32'd0, 32'd0, 4);
        // Boundary ops.
        txn(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 3'd1, 32'd0, 32'd1, 0);
        txn(1'b1, 1'b0, 3'd6, 32'hFFFF_FFFF, 32'd1, 3'd0, 32'd0, 32'd0, 0);
        txn(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 3'd6, 32'd1, 32'hFFFF_FFFF, 1);
        txn(1'b1, 1'b0, 3'd7, 32'h1234_5678, 32'd9, 3'd0, 32'd0, 32'd0, 0);

        // Neither valid: no grant, no response.
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("idle_ready0", 32'(req0_ready), 32'd0);
        chk("idle_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // Reset while the op is in EXEC drops it.
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd1; req0_b = 32'd2;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midop_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midop_ready0", 32'(req0_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_last = 1'b1;
        @(negedge clk);
        chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        txn(1'b1, 1'b1, 3'd4, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 3'd3, 32'd1, 32'd2, 0);
        txn(1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 3'd0, 32'hFFFF_FFFF, 32'd1, 0);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            bit          v0, v1;
            logic [31:0] a0, a1;
            v0 = 1'($urandom_range(0, 1));
            v1 = (v0 == 1'b0) ? 1'b1 : 1'($urandom_range(0, 1));
            a0 = $urandom;
            a1 = $urandom;
            txn(v0, v1, 3'($urandom), a0, (k % 5 == 0) ? a0 : $urandom,
                3'($urandom), a1, (k % 7 == 0) ? a1 : $urandom,
                int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
